// File: rtl/div_issue.sv
// Issue/hold stage in front of an iterative divider: holds one operation, starts the
// divider, short-circuits divide-by-zero and returns the result with its destination tag.
package div_issue_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_MOD  = 2'd2,
        DIV_MODU = 2'd3
    } div_opcode_t;
endpackage

module div_issue
    import div_issue_pkg::*;
#(
    parameter int DEST_W    = 5,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  div_opcode_t       in_opcode,
    input  logic [31:0]       in_src1,
    input  logic [31:0]       in_src2,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              flush,
    output logic              div_valid,
    output div_opcode_t       div_opcode,
    output logic [31:0]       div_src1,
    output logic [31:0]       div_src2,
    input  logic              div_ok,
    input  logic [31:0]       div_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Architectural divide-by-zero result: all ones for quotients, dividend for remainders.
    function automatic logic [31:0] zero_div_result(input div_opcode_t op, input logic [31:0] src1);
        logic [31:0] res;
        case (op)
            DIV_DIV, DIV_DIVU: res = 32'hFFFF_FFFF;
            DIV_MOD, DIV_MODU: res = src1;
            default:           res = 32'hFFFF_FFFF;
        endcase
        return res;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [31:0]         result_r;
    logic [31:0]         result_s;
    logic [DEST_W-1:0]   dest_r;
    logic [DEST_W-1:0]   dest_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                accept_s;
    logic                bypass_s;

    // Accept qualification; resetn gates it so no start pulse escapes during reset.
    always_comb begin
        accept_s = in_valid & in_ready_r & ~flush & resetn;
        bypass_s = ZERO_FAST && (in_src2 == 32'd0);
    end

    assign div_valid  = accept_s & ~bypass_s;
    assign div_opcode = in_opcode;
    assign div_src1   = in_src1;
    assign div_src2   = in_src2;

    // Next-state and result/tag capture.
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        dest_s   = dest_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    dest_s = in_dest;
                    if (bypass_s) begin
                        result_s = zero_div_result(in_opcode, in_src1);
                        state_s  = ST_DONE;
                    end else begin
                        state_s  = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A flush racing the completion wins: the result is dropped.
                if (flush && div_ok) begin
                    state_s = ST_IDLE;
                end else if (flush) begin
                    state_s = ST_DRAIN;
                end else if (div_ok) begin
                    result_s = div_result;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (div_ok) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, held result and registered status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            result_r    <= 32'd0;
            dest_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            result_r    <= result_s;
            dest_r      <= dest_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign out_result = result_r;
    assign out_dest   = dest_r;

endmodule

// File: tb/tb_div_issue.sv
// Directed, table-driven bench for div_issue; the bench plays the divider with a fixed latency.
module tb_div_issue;
    import div_issue_pkg::*;

    localparam int LAT = 3;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    div_opcode_t in_opcode;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_dest;
    logic        flush;
    logic        div_valid;
    div_opcode_t div_opcode;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_ok;
    logic [31:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        div_opcode_t op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        bypass;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[8];

    div_issue #(.DEST_W(5), .ZERO_FAST(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src1(in_src1), .in_src2(in_src2), .in_dest(in_dest),
        .flush(flush),
        .div_valid(div_valid), .div_opcode(div_opcode), .div_src1(div_src1), .div_src2(div_src2),
        .div_ok(div_ok), .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input div_opcode_t op, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [4:0] d);
        in_valid  = 1'b1;
        in_opcode = op;
        in_src1   = s1;
        in_src2   = s2;
        in_dest   = d;
    endtask

    task automatic run_vector(input vec_t v);
        out_ready = 1'b1;
        drive_op(v.op, v.src1, v.src2, v.dest);
        @(negedge clk);
        check("vec_in_ready", {31'd0, in_ready}, 32'd1);
        check("vec_div_valid", {31'd0, div_valid}, {31'd0, ~v.bypass});
        if (!v.bypass) begin
            check("vec_div_src1", div_src1, v.src1);
            check("vec_div_src2", div_src2, v.src2);
            check("vec_div_opcode", {30'd0, div_opcode}, {30'd0, v.op});
        end
        step();
        in_valid = 1'b0;
        if (!v.bypass) begin
            for (int k = 0; k < LAT; k++) begin
                @(negedge clk);
                check("vec_wait_div_valid", {31'd0, div_valid}, 32'd0);
                check("vec_wait_out_valid", {31'd0, out_valid}, 32'd0);
                check("vec_wait_in_ready", {31'd0, in_ready}, 32'd0);
                step();
            end
            div_ok     = 1'b1;
            div_result = v.result;
            step();
            div_ok     = 1'b0;
            div_result = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        check("vec_out_valid", {31'd0, out_valid}, 32'd1);
        check("vec_out_result", out_result, v.result);
        check("vec_out_dest", {27'd0, out_dest}, {27'd0, v.dest});
        check("vec_busy", {31'd0, busy}, 32'd1);
        step();
        @(negedge clk);
        check("vec_idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("vec_idle_in_ready", {31'd0, in_ready}, 32'd1);
        step();
    endtask

    initial begin
        vecs[0] = '{DIV_DIV,  32'hFFFF_FFF9, 32'd2,  5'd3,  1'b0, 32'hFFFF_FFFD};
        vecs[1] = '{DIV_DIVU, 32'd123,       32'd0,  5'd7,  1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{DIV_MOD,  32'd123,       32'd0,  5'd8,  1'b1, 32'd123};
        vecs[3] = '{DIV_MODU, 32'd100,       32'd7,  5'd1,  1'b0, 32'd2};
        vecs[4] = '{DIV_DIVU, 32'd1000,      32'd10, 5'd31, 1'b0, 32'd100};
        vecs[5] = '{DIV_MOD,  32'd9,         32'd4,  5'd2,  1'b0, 32'd1};
        vecs[6] = '{DIV_DIV,  32'h8000_0000, 32'd0,  5'd4,  1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{DIV_MODU, 32'hFFFF_FFFF, 32'd0,  5'd5,  1'b1, 32'hFFFF_FFFF};

        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = DIV_DIV;
        in_src1    = 32'd0;
        in_src2    = 32'd0;
        in_dest    = 5'd0;
        flush      = 1'b0;
        div_ok     = 1'b0;
        div_result = 32'd0;
        out_ready  = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_div_valid", {31'd0, div_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_dest", {27'd0, out_dest}, 32'd0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        for (int i = 0; i < 8; i++) run_vector(vecs[i]);

        // Result held under backpressure; stray div_ok in DONE ignored
        out_ready = 1'b0;
        drive_op(DIV_MODU, 32'd100, 32'd7, 5'd9);
        step();
        in_valid = 1'b0;
        step();
        div_ok = 1'b1; div_result = 32'd2;
        step();
        div_ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                div_ok = 1'b1; div_result = 32'd77;
            end else begin
                div_ok = 1'b0;
            end
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_result", out_result, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        div_ok = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_busy", {31'd0, busy}, 32'd0);
        step();

        // div_ok while idle leaves everything unchanged
        div_ok = 1'b1; div_result = 32'h1234_5678;
        step();
        div_ok = 1'b0;
        @(negedge clk);
        check("idle_divok_busy", {31'd0, busy}, 32'd0);
        check("idle_divok_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_divok_result", out_result, 32'd2);
        step();

        // Flush three cycles after accept -> DRAIN until div_ok
        drive_op(DIV_DIV, 32'd50, 32'd5, 5'd6);
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drain_in_ready", {31'd0, in_ready}, 32'd0);
            check("drain_out_valid", {31'd0, out_valid}, 32'd0);
            check("drain_busy", {31'd0, busy}, 32'd1);
            flush = (k == 1);
            step();
        end
        flush = 1'b0;
        div_ok = 1'b1; div_result = 32'd10;
        step();
        div_ok = 1'b0;
        @(negedge clk);
        check("drain_done_in_ready", {31'd0, in_ready}, 32'd1);
        check("drain_done_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        run_vector(vecs[5]);

        // Flush coincident with div_ok
        drive_op(DIV_DIV, 32'd20, 32'd4, 5'd10);
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; div_ok = 1'b1; div_result = 32'd5;
        step();
        flush = 1'b0; div_ok = 1'b0;
        @(negedge clk);
        check("flush_ok_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ok_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // Flush in DONE: out_valid still reads 1, then IDLE without handshake
        out_ready = 1'b0;
        drive_op(DIV_DIVU, 32'd5, 32'd0, 5'd11);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("done_flush_out_valid", {31'd0, out_valid}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("done_flush_after_valid", {31'd0, out_valid}, 32'd0);
        check("done_flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();

        // Flush blocks accept in IDLE
        drive_op(DIV_DIV, 32'd8, 32'd2, 5'd12);
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_div_valid", {31'd0, div_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        step();

        // Reset while waiting, then late div_ok
        drive_op(DIV_DIVU, 32'd64, 32'd8, 5'd13);
        step();
        in_valid = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        check("wait_rst_busy", {31'd0, busy}, 32'd0);
        check("wait_rst_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        resetn = 1'b1;
        div_ok = 1'b1; div_result = 32'd8;
        step();
        div_ok = 1'b0;
        @(negedge clk);
        check("late_ok_out_valid", {31'd0, out_valid}, 32'd0);
        check("late_ok_busy", {31'd0, busy}, 32'd0);
        check("late_ok_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
